// File: rtl/apple_iie_mem_pkg.sv
// Shared tick constants, phase type and CPU capture payload for the Apple IIe
// DRAM cycle scheduler.
package apple_iie_mem_pkg;

  localparam int unsigned TICK_W  = 5;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned RAM_A_W = 8;

  typedef logic [TICK_W-1:0] tick_t;

  // Video half of the cycle
  localparam tick_t T_VID_ROW   = 5'd0;
  localparam tick_t T_VID_RAS   = 5'd1;
  localparam tick_t T_VID_COL   = 5'd2;
  localparam tick_t T_VID_CAS   = 5'd3;
  localparam tick_t T_VID_LATCH = 5'd5;
  localparam tick_t T_VID_END   = 5'd6;

  // CPU half of the cycle
  localparam tick_t T_CPU_ROW   = 5'd7;
  localparam tick_t T_CPU_RAS   = 5'd8;
  localparam tick_t T_CPU_COL   = 5'd9;
  localparam tick_t T_CPU_CAS   = 5'd10;
  localparam tick_t T_CPU_LATCH = 5'd12;
  localparam tick_t T_CPU_END   = 5'd13;

  typedef enum logic [1:0] {PH_VIDEO, PH_CPU, PH_STRETCH} phase_e;

  // CPU request as captured at the start of the CPU half
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic              rw_n;
    logic              req;
    logic              aux;
  } cpu_req_t;

  // Which half of the cycle a tick belongs to
  function automatic phase_e phase_of(input tick_t t);
    if (t < T_CPU_ROW)       return PH_VIDEO;
    else if (t <= T_CPU_END) return PH_CPU;
    else                     return PH_STRETCH;
  endfunction

endpackage

// File: rtl/apple_iie_cycle_phase_counter.sv
// Master-clock tick counter for one CPU cycle, with the stretched-cycle option.
// Ports:
//   clk_14m, reset     : master clock, synchronous active-high reset
//   vid_long_cycle     : sampled at tick SHORT_TICKS-2, stretches this cycle
//   t_next_c           : combinational tick value for the coming clock tick
//   clk_phi_0/1        : registered CPU clock and its complement
//   vid_advance        : registered pulse on the last tick of each cycle
module apple_iie_cycle_phase_counter
  import apple_iie_mem_pkg::*;
#(
  parameter int unsigned SHORT_TICKS = 14,
  parameter int unsigned LONG_TICKS  = 16
) (
  input  logic  clk_14m,
  input  logic  reset,
  input  logic  vid_long_cycle,
  output tick_t t_next_c,
  output logic  clk_phi_0,
  output logic  clk_phi_1,
  output logic  vid_advance
);

  localparam tick_t LAST_SHORT = tick_t'(SHORT_TICKS - 1);
  localparam tick_t LAST_LONG  = tick_t'(LONG_TICKS - 1);
  localparam tick_t T_SAMPLE   = tick_t'(SHORT_TICKS - 2);

  tick_t t;
  logic  long_q;
  logic  long_next;
  logic  phi0_d;
  logic  adv_d;

  // State register
  always_ff @(posedge clk_14m) begin
    if (reset) begin
      t           <= '0;
      long_q      <= 1'b0;
      clk_phi_0   <= 1'b0;
      clk_phi_1   <= 1'b1;
      vid_advance <= 1'b0;
    end else begin
      t           <= t_next_c;
      long_q      <= long_next;
      clk_phi_0   <= phi0_d;
      clk_phi_1   <= ~phi0_d;
      vid_advance <= adv_d;
    end
  end

  // Next tick; the long flag is latched once per cycle and cleared on wrap
  always_comb begin
    t_next_c  = tick_t'(t + tick_t'(1));
    long_next = long_q;
    if (t == (long_q ? LAST_LONG : LAST_SHORT)) begin
      t_next_c = '0;
    end
    if (t == T_SAMPLE) begin
      long_next = vid_long_cycle;
    end else if (t_next_c == '0) begin
      long_next = 1'b0;
    end
  end

  // Output decode of the coming tick
  always_comb begin
    phi0_d = (t_next_c >= T_CPU_ROW);
    adv_d  = (t_next_c == (long_next ? LAST_LONG : LAST_SHORT));
  end

endmodule

// File: rtl/apple_iie_memory_cycle_scheduler.sv
// Time-multiplexes the shared DRAM between the video scanner (phi1 half) and
// the CPU (phi0 half): address mux, RAS/CAS/WE strobes and data-latch pulses.
// Ports:
//   clk_14m, reset                       : master clock, sync active-high reset
//   vid_a, vid_aux, vid_long_cycle       : video scanner fetch request
//   cpu_a, cpu_rw_n, cpu_req, cpu_aux    : CPU access request
//   clk_phi_0, clk_phi_1, vid_advance    : cycle timing outputs
//   ram_a, ras_n, cas_n, we_n, bank_aux  : DRAM interface
//   vid_latch, cpu_latch, cpu_done       : one-tick data strobes
module apple_iie_memory_cycle_scheduler
  import apple_iie_mem_pkg::*;
#(
  parameter int unsigned SHORT_TICKS = 14,
  parameter int unsigned LONG_TICKS  = 16
) (
  input  logic               clk_14m,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  vid_a,
  input  logic               vid_aux,
  input  logic               vid_long_cycle,
  input  logic [ADDR_W-1:0]  cpu_a,
  input  logic               cpu_rw_n,
  input  logic               cpu_req,
  input  logic               cpu_aux,
  output logic               clk_phi_0,
  output logic               clk_phi_1,
  output logic               vid_advance,
  output logic [RAM_A_W-1:0] ram_a,
  output logic               ras_n,
  output logic               cas_n,
  output logic               we_n,
  output logic               bank_aux,
  output logic               vid_latch,
  output logic               cpu_latch,
  output logic               cpu_done
);

  tick_t tn;
  phase_e ph;

  logic [ADDR_W-1:0]  vid_a_q;
  logic               vid_aux_q;
  cpu_req_t           cpu_q;
  cpu_req_t           cpu_in;
  cpu_req_t           cpu_sel;
  logic [ADDR_W-1:0]  vid_a_sel;
  logic               vid_aux_sel;

  logic [RAM_A_W-1:0] ram_a_d;
  logic               bank_d;
  logic               ras_d;
  logic               cas_d;
  logic               we_d;
  logic               vl_d;
  logic               cl_d;
  logic               cd_d;

  apple_iie_cycle_phase_counter #(
    .SHORT_TICKS (SHORT_TICKS),
    .LONG_TICKS  (LONG_TICKS)
  ) u_phase (
    .clk_14m        (clk_14m),
    .reset          (reset),
    .vid_long_cycle (vid_long_cycle),
    .t_next_c       (tn),
    .clk_phi_0      (clk_phi_0),
    .clk_phi_1      (clk_phi_1),
    .vid_advance    (vid_advance)
  );

  // Requests are taken live on their capture tick, from the capture registers after
  always_comb begin
    cpu_in.a    = cpu_a;
    cpu_in.rw_n = cpu_rw_n;
    cpu_in.req  = cpu_req;
    cpu_in.aux  = cpu_aux;
    cpu_sel     = (tn == T_CPU_ROW) ? cpu_in  : cpu_q;
    vid_a_sel   = (tn == T_VID_ROW) ? vid_a   : vid_a_q;
    vid_aux_sel = (tn == T_VID_ROW) ? vid_aux : vid_aux_q;
    ph          = phase_of(tn);
  end

  // Strobe and address decode for the coming tick
  always_comb begin
    ram_a_d = ram_a;
    bank_d  = bank_aux;
    ras_d   = 1'b1;
    cas_d   = 1'b1;
    we_d    = 1'b1;
    vl_d    = 1'b0;
    cl_d    = 1'b0;
    cd_d    = 1'b0;
    case (ph)
      PH_VIDEO: begin
        // Row also re-driven at the RAS tick so the slot after reset is correct
        if (tn < T_VID_COL) begin
          ram_a_d = vid_a_sel[RAM_A_W-1:0];
          bank_d  = vid_aux_sel;
        end else begin
          ram_a_d = vid_a_sel[ADDR_W-1:RAM_A_W];
        end
        ras_d = !((tn >= T_VID_RAS) && (tn < T_VID_END));
        cas_d = !((tn >= T_VID_CAS) && (tn < T_VID_END));
        vl_d  = (tn == T_VID_LATCH);
      end
      PH_CPU: begin
        if (cpu_sel.req) begin
          if (tn < T_CPU_COL) begin
            ram_a_d = cpu_sel.a[RAM_A_W-1:0];
            bank_d  = cpu_sel.aux;
          end else begin
            ram_a_d = cpu_sel.a[ADDR_W-1:RAM_A_W];
          end
          ras_d = !((tn >= T_CPU_RAS) && (tn < T_CPU_END));
          cas_d = !((tn >= T_CPU_CAS) && (tn < T_CPU_END));
          we_d  = !((tn >= T_CPU_CAS) && (tn < T_CPU_END) && !cpu_sel.rw_n);
          cl_d  = (tn == T_CPU_LATCH) && cpu_sel.rw_n;
          cd_d  = (tn == T_CPU_LATCH);
        end
      end
      default: ;
    endcase
  end

  // Output and capture registers; video request is also taken on the reset edge
  always_ff @(posedge clk_14m) begin
    if (reset) begin
      ram_a     <= '0;
      bank_aux  <= 1'b0;
      ras_n     <= 1'b1;
      cas_n     <= 1'b1;
      we_n      <= 1'b1;
      vid_latch <= 1'b0;
      cpu_latch <= 1'b0;
      cpu_done  <= 1'b0;
      vid_a_q   <= vid_a;
      vid_aux_q <= vid_aux;
      cpu_q     <= '0;
    end else begin
      ram_a     <= ram_a_d;
      bank_aux  <= bank_d;
      ras_n     <= ras_d;
      cas_n     <= cas_d;
      we_n      <= we_d;
      vid_latch <= vl_d;
      cpu_latch <= cl_d;
      cpu_done  <= cd_d;
      if (tn == T_VID_ROW) begin
        vid_a_q   <= vid_a;
        vid_aux_q <= vid_aux;
      end
      if (tn == T_CPU_ROW) begin
        cpu_q <= cpu_in;
      end
    end
  end

endmodule

// File: doc/apple_iie_memory_cycle_scheduler.md
Name: apple_iie_memory_cycle_scheduler

Overview:
Time-multiplexes the shared 64K DRAM between the video scanner and the CPU.
- Divides each 14M master-clock cycle group into a video half (phi1) and a CPU half (phi0).
- Generates phi0/phi1 and the multiplexed row/column address.
- Drives RAS/CAS/WE strobes and the data-latch strobes.
- Issues the step enable that advances the video scanner, including the stretched 65th cycle of each line.

Parameters:
SHORT_TICKS, 14, master-clock ticks per normal CPU cycle.
LONG_TICKS, 16, master-clock ticks per stretched cycle (must be >= SHORT_TICKS).

Ports:
clk_14m  in  1  master clock; all logic on posedge.
reset  in  1  synchronous, active-high.
vid_a  in  16  video scanner display address.
vid_aux  in  1  bank for video fetch (1 = aux).
vid_long_cycle  in  1  scanner flags that the current cycle is the stretched one.
cpu_a  in  16  CPU address.
cpu_rw_n  in  1  1 = read, 0 = write.
cpu_req  in  1  CPU wants RAM this cycle.
cpu_aux  in  1  bank for CPU access.
clk_phi_0  out  1  CPU clock.
clk_phi_1  out  1  complement of clk_phi_0.
vid_advance  out  1  one-tick pulse stepping the scanner.
ram_a  out  8  multiplexed DRAM address.
ras_n  out  1  row strobe.
cas_n  out  1  column strobe.
we_n  out  1  write enable.
bank_aux  out  1  selects the aux RAM bank.
vid_latch  out  1  one-tick pulse to capture video data.
cpu_latch  out  1  one-tick pulse to capture CPU read data.
cpu_done  out  1  one-tick pulse marking the end of a CPU access.

Behaviour:
- All outputs are registered. Reset values: tick t=0, clk_phi_0=0, clk_phi_1=1, ras_n=cas_n=we_n=1, ram_a=0, bank_aux=0, all pulses 0.
- Reset is honoured on any tick. Strobes return high on the reset edge; there is no partial access completion.
- Tick counter t:
  - Counts 0..SHORT_TICKS-1, or 0..LONG_TICKS-1 when the cycle is long.
  - vid_long_cycle is sampled at t=SHORT_TICKS-2 and selects the length of the current cycle.
- clk_phi_0 = 0 for t in 0..6 and 1 for t >= 7. A long cycle therefore stretches the phi0-high half only.
- Video half (t0..t6), always performed:
  - t0: capture vid_a and vid_aux; ram_a = vid_a[7:0]; bank_aux = vid_aux.
  - t1: ras_n = 0.
  - t2: ram_a = vid_a[15:8].
  - t3: cas_n = 0.
  - t5: vid_latch pulse.
  - t6: ras_n = cas_n = 1.
- CPU half (t7..t13):
  - t7: capture cpu_a, cpu_rw_n, cpu_req, cpu_aux.
  - If the captured request is 0, ras_n, cas_n and we_n stay high for the whole half, and no cpu_latch or cpu_done pulses occur.
  - Otherwise:
    - t7: ram_a = cpu_a[7:0]; bank_aux = cpu_aux.
    - t8: ras_n = 0.
    - t9: ram_a = cpu_a[15:8].
    - t10: cas_n = 0; we_n = 0 if the access is a write.
    - t12: cpu_latch pulses (reads only); cpu_done pulses (reads and writes).
    - t13: ras_n = cas_n = we_n = 1.
- Long-cycle ticks t14..t15 are idle: no strobes, ram_a holds its value.
- vid_advance pulses on the last tick of each cycle (t13 for a short cycle, t15 for a long one), so the scanner steps exactly once per CPU cycle.
- Input changes outside their capture tick have no effect.
- The video and CPU strobes never overlap: ras_n is high at t0 and at t7.

Decomposition:
- Shared package apple_iie_mem_pkg holds:
  - tick constants T_VID_ROW=0, T_VID_RAS=1, T_VID_COL=2, T_VID_CAS=3, T_VID_LATCH=5, T_VID_END=6;
  - the CPU-half equivalents (+7);
  - a phase typedef {PH_VIDEO, PH_CPU, PH_STRETCH}.
- One natural sub-module, apple_iie_cycle_phase_counter, owns:
  - the t counter;
  - long-cycle sampling;
  - clk_phi_0 and clk_phi_1;
  - vid_advance.
- The top level decodes t into the strobes and the address mux.

Test Plan:
- Reset for 3 ticks, then release: all outputs at reset values; clk_phi_0 rises at the 7th tick after release; vid_advance pulses on tick 13.
- Hold vid_a=0x2C35, vid_aux=1: ram_a=0x35 at t0..t1 and 0x2C at t2..t5; bank_aux=1; vid_latch high only at t5.
- cpu_req=1, cpu_rw_n=0, cpu_a=0x0801: ram_a=0x01 then 0x08; we_n low t10..t12; cpu_latch never pulses; cpu_done pulses at t12.
- cpu_req=0 across 5 cycles: ras_n pulses once per cycle (video only); cpu_done is never asserted.
- vid_long_cycle=1 in one cycle: that cycle lasts 16 ticks with clk_phi_0 high for 9 ticks and vid_advance at t15; the next cycle is 14 ticks.
- Assert reset at t10 of a CPU write: ras_n, cas_n and we_n are high on the reset edge; there is no cpu_done pulse; a clean video slot follows the release.
